rti_unstack_sequencer: RTL and testbench

Multi-cycle sequencer for RET and RTI. It pops the saved context off the data-memory stack in the reverse of the order the interrupt push sequence writes it: flags word first, then PC low, then PC high. It then reassembles the 32-bit return PC and restores the 3-bit flag register. It sits beside the memory stage, drives that stage's `pop` control, and holds the front of the pipeline stalled until the return address is available.

---
 rtl/rti_unstack_sequencer.sv | 150 +++++++++++++++
 tb/tb_rti_unstack_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rti_unstack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rti_unstack_sequencer
// Description : RET/RTI unstack sequencer. Pops flags (RTI only), PC low and
//               PC high from the data-memory stack. It then restores the
//               return PC and flags, and stalls the pipeline front while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module rti_unstack_sequencer #(
  parameter int PC_W   = 32,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_ret,
  input  logic              start_rti,
  input  logic              hold,
  input  logic [15:0]       mem_rdata,
  output logic              pop,
  output logic              stall,
  output logic              int_block,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_out,
  output logic              flag_load,
  output logic [FLAG_W-1:0] flag_out
);

  localparam int HALF_W = PC_W / 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP_FLAGS = 3'd1,
    S_POP_LO    = 3'd2,
    S_POP_HI    = 3'd3,
    S_LOAD      = 3'd4
  } state_t;

  state_t              state;
  state_t              next_state;
  logic                is_rti;
  logic [FLAG_W-1:0]   flag_shadow;
  logic [HALF_W-1:0]   pc_lo_shadow;

  // State register; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode; a pop step only advances when not held.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    stall      = 1'b0;
    int_block  = 1'b0;
    pc_load    = 1'b0;
    flag_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_rti) begin
          next_state = S_POP_FLAGS;
        end else if (start_ret) begin
          next_state = S_POP_LO;
        end
      end
      S_POP_FLAGS: begin
        stall     = 1'b1;
        int_block = 1'b1;
        if (!hold) begin
          pop        = 1'b1;
          next_state = S_POP_LO;
        end
      end
      S_POP_LO: begin
        stall     = 1'b1;
        int_block = 1'b1;
        if (!hold) begin
          pop        = 1'b1;
          next_state = S_POP_HI;
        end
      end
      S_POP_HI: begin
        stall     = 1'b1;
        int_block = 1'b1;
        if (!hold) begin
          pop        = 1'b1;
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        stall      = 1'b1;
        int_block  = 1'b1;
        pc_load    = 1'b1;
        flag_load  = is_rti;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Mode latch, shadow capture and output registers. The output registers
  // load on the edge into LOAD, so pc_out/flag_out are already valid while
  // pc_load/flag_load are high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_rti       <= 1'b0;
      flag_shadow  <= '0;
      pc_lo_shadow <= '0;
      pc_out       <= '0;
      flag_out     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_rti) begin
            is_rti <= 1'b1;
          end else if (start_ret) begin
            is_rti <= 1'b0;
          end
        end
        S_POP_FLAGS: begin
          if (!hold) begin
            flag_shadow <= mem_rdata[FLAG_W-1:0];
          end
        end
        S_POP_LO: begin
          if (!hold) begin
            pc_lo_shadow <= mem_rdata[HALF_W-1:0];
          end
        end
        S_POP_HI: begin
          if (!hold) begin
            pc_out <= {mem_rdata[HALF_W-1:0], pc_lo_shadow};
            if (is_rti) begin
              flag_out <= flag_shadow;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rti_unstack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rti_unstack_sequencer
// Description : Directed self-checking bench for rti_unstack_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rti_unstack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_ret;
  logic        start_rti;
  logic        hold;
  logic [15:0] mem_rdata;
  logic        pop;
  logic        stall;
  logic        int_block;
  logic        pc_load;
  logic [31:0] pc_out;
  logic        flag_load;
  logic [2:0]  flag_out;

  int checks   = 0;
  int failures = 0;

  // Stack model: words are read in pop order starting at base.
  logic [15:0] stk [0:7];
  int          pop_cnt = 0;
  int          base    = 0;
  logic [2:0]  rd_idx;

  assign rd_idx    = 3'(pop_cnt - base);
  assign mem_rdata = stk[rd_idx];

  always #5 clk = ~clk;

  // Memory stage: SP advances once per cycle with pop high.
  always @(posedge clk) begin
    if (pop === 1'b1) pop_cnt <= pop_cnt + 1;
  end

  rti_unstack_sequencer #(.PC_W(32), .FLAG_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_ret (start_ret),
    .start_rti (start_rti),
    .hold      (hold),
    .mem_rdata (mem_rdata),
    .pop       (pop),
    .stall     (stall),
    .int_block (int_block),
    .pc_load   (pc_load),
    .pc_out    (pc_out),
    .flag_load (flag_load),
    .flag_out  (flag_out)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_stack(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2);
    for (int i = 0; i < 8; i++) stk[i] = 16'h0000;
    stk[0] = w0;
    stk[1] = w1;
    stk[2] = w2;
    base   = pop_cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_rti = 1'b1; start_ret = 1'b1; hold = 1'b0;
    load_stack(16'h0, 16'h0, 16'h0);
    next_cycle();
    next_cycle();
    checks++;
    if ({pop, stall, int_block, pc_load, flag_load} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000", {pop, stall, int_block, pc_load, flag_load});
    end
    checks++;
    if (pc_out !== 32'h0 || flag_out !== 3'h0) begin
      failures++;
      $display("FAIL reset_data got pc=%h fl=%b want pc=00000000 fl=000", pc_out, flag_out);
    end
    start_rti = 1'b0; start_ret = 1'b0; rst_n = 1'b1;
    next_cycle();
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_ignored got stall=%b want 0", stall);
    end
  endtask

  task automatic test_rti();
    int p0;
    load_stack(16'h0005, 16'h1234, 16'h0002);
    p0 = pop_cnt;
    start_rti = 1'b1;
    next_cycle();
    start_rti = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (pop !== (c <= 3)) begin
        failures++;
        $display("FAIL rti_pop c%0d got=%b want=%b", c, pop, (c <= 3));
      end
      checks++;
      if (stall !== (c <= 4) || int_block !== (c <= 4)) begin
        failures++;
        $display("FAIL rti_busy c%0d got=%b%b want=%b", c, stall, int_block, (c <= 4));
      end
      checks++;
      if (pc_load !== (c == 4) || flag_load !== (c == 4)) begin
        failures++;
        $display("FAIL rti_load c%0d got=%b%b want=%b", c, pc_load, flag_load, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (pc_out !== 32'h0002_1234 || flag_out !== 3'b101) begin
          failures++;
          $display("FAIL rti_value got pc=%h fl=%b want pc=00021234 fl=101", pc_out, flag_out);
        end
      end
      if (c < 5) next_cycle();
    end
    checks++;
    if (pop_cnt - p0 !== 3) begin
      failures++;
      $display("FAIL rti_pop_count got=%0d want=3", pop_cnt - p0);
    end
  endtask

  task automatic test_ret();
    int p0;
    load_stack(16'hBEEF, 16'hDEAD, 16'h0000);
    p0 = pop_cnt;
    start_ret = 1'b1;
    next_cycle();
    start_ret = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (pop !== (c <= 2)) begin
        failures++;
        $display("FAIL ret_pop c%0d got=%b want=%b", c, pop, (c <= 2));
      end
      checks++;
      if (stall !== (c <= 3) || pc_load !== (c == 3) || flag_load !== 1'b0) begin
        failures++;
        $display("FAIL ret_ctrl c%0d got=%b%b%b want=%b%b0", c, stall, pc_load, flag_load, (c <= 3), (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (pc_out !== 32'hDEAD_BEEF || flag_out !== 3'b101) begin
          failures++;
          $display("FAIL ret_value got pc=%h fl=%b want pc=deadbeef fl=101", pc_out, flag_out);
        end
      end
      if (c < 4) next_cycle();
    end
    checks++;
    if (pop_cnt - p0 !== 2) begin
      failures++;
      $display("FAIL ret_pop_count got=%0d want=2", pop_cnt - p0);
    end
  endtask

  task automatic test_hold();
    int p0;
    logic [6:0] exp_pop;
    exp_pop = 7'b0011001;  // bit c-1: pops in cycles 1, 4, 5
    load_stack(16'h0005, 16'h1234, 16'h0002);
    p0 = pop_cnt;
    start_rti = 1'b1;
    next_cycle();
    start_rti = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) hold = 1'b1;
      if (c == 4) hold = 1'b0;
      #1;
      checks++;
      if (pop !== exp_pop[c-1]) begin
        failures++;
        $display("FAIL hold_pop c%0d got=%b want=%b", c, pop, exp_pop[c-1]);
      end
      checks++;
      if (stall !== (c <= 6) || pc_load !== (c == 6) || flag_load !== (c == 6)) begin
        failures++;
        $display("FAIL hold_ctrl c%0d got=%b%b%b want=%b%b%b", c, stall, pc_load, flag_load, (c <= 6), (c == 6), (c == 6));
      end
      if (c == 6) begin
        checks++;
        if (pc_out !== 32'h0002_1234 || flag_out !== 3'b101) begin
          failures++;
          $display("FAIL hold_value got pc=%h fl=%b want pc=00021234 fl=101", pc_out, flag_out);
        end
      end
      if (c < 7) next_cycle();
    end
    checks++;
    if (pop_cnt - p0 !== 3) begin
      failures++;
      $display("FAIL hold_pop_count got=%0d want=3", pop_cnt - p0);
    end
  endtask

  task automatic test_both_starts();
    int p0;
    load_stack(16'h0003, 16'h5678, 16'h9ABC);
    p0 = pop_cnt;
    start_rti = 1'b1; start_ret = 1'b1;
    next_cycle();
    start_rti = 1'b0; start_ret = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      start_ret = (c == 2);
      checks++;
      if (pop !== (c <= 3) || stall !== (c <= 4)) begin
        failures++;
        $display("FAIL both_ctrl c%0d got pop=%b stall=%b want pop=%b stall=%b", c, pop, stall, (c <= 3), (c <= 4));
      end
      if (c == 4) begin
        checks++;
        if (pc_load !== 1'b1 || flag_load !== 1'b1 || pc_out !== 32'h9ABC_5678 || flag_out !== 3'b011) begin
          failures++;
          $display("FAIL both_value got %b%b pc=%h fl=%b want 11 pc=9abc5678 fl=011", pc_load, flag_load, pc_out, flag_out);
        end
      end
      if (c < 6) next_cycle();
    end
    start_ret = 1'b0;
    checks++;
    if (pop_cnt - p0 !== 3) begin
      failures++;
      $display("FAIL both_pop_count got=%0d want=3", pop_cnt - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    load_stack(16'h0006, 16'h1111, 16'h2222);
    start_rti = 1'b1;
    next_cycle();
    start_rti = 1'b0;
    next_cycle();
    next_cycle();          // cycle 3: POP_HI
    rst_n = 1'b0;
    next_cycle();          // cycle 4: after reset
    rst_n = 1'b1;
    checks++;
    if ({pop, stall, int_block, pc_load, flag_load} !== 5'b0) begin
      failures++;
      $display("FAIL rstmid_ctrl got=%b want=00000", {pop, stall, int_block, pc_load, flag_load});
    end
    checks++;
    if (pc_out !== 32'h0 || flag_out !== 3'h0) begin
      failures++;
      $display("FAIL rstmid_data got pc=%h fl=%b want pc=00000000 fl=000", pc_out, flag_out);
    end
    next_cycle();
    checks++;
    if (pc_load !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle got pc_load=%b stall=%b want 0 0", pc_load, stall);
    end
    load_stack(16'hCAFE, 16'h0123, 16'h0000);
    p0 = pop_cnt;
    start_ret = 1'b1;
    next_cycle();
    start_ret = 1'b0;
    next_cycle();
    next_cycle();          // cycle 3: LOAD
    checks++;
    if (pc_load !== 1'b1 || flag_load !== 1'b0 || pc_out !== 32'h0123_CAFE || flag_out !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_ret got %b%b pc=%h fl=%b want 10 pc=0123cafe fl=000", pc_load, flag_load, pc_out, flag_out);
    end
    checks++;
    if (pop_cnt - p0 !== 2) begin
      failures++;
      $display("FAIL rstmid_pop_count got=%0d want=2", pop_cnt - p0);
    end
    next_cycle();
  endtask

  task automatic test_flag_mask();
    load_stack(16'hFFFA, 16'h0000, 16'h0000);
    start_rti = 1'b1;
    next_cycle();
    start_rti = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (stall !== (c <= 4) || int_block !== (c <= 4)) begin
        failures++;
        $display("FAIL mask_busy c%0d got=%b%b want=%b", c, stall, int_block, (c <= 4));
      end
      if (c == 4) begin
        checks++;
        if (flag_load !== 1'b1 || flag_out !== 3'b010 || pc_out !== 32'h0) begin
          failures++;
          $display("FAIL mask_value got fl_load=%b fl=%b pc=%h want 1 010 00000000", flag_load, flag_out, pc_out);
        end
      end
      if (c < 5) next_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0; start_rti = 1'b0; start_ret = 1'b0; hold = 1'b0;
    test_reset();
    test_rti();
    test_ret();
    test_hold();
    test_both_starts();
    test_reset_mid();
    test_flag_mask();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
